prompt_response_judge: RTL and testbench
========================================

Name: prompt_response_judge

Overview:
Player-side end of the LED prompt protocol: accepts a one-hot switch prompt, watches the board switches, debounces the player's response and judges it against the prompt. Reports exactly one verdict per prompt (correct / wrong / timeout / bad prompt) over a valid/ready handshake, and counts down the per-round time limit. Sits between the prompt generator and the round/score logic; secs_left feeds the HEX timer digits.

Parameters:
DEBOUNCE_CYCLES, 1000000, clk cycles the switch vector must be stable before judging (20 ms at 50 MHz); min 1
TICK_DIV, 50000000, clk cycles per countdown second; min 1
TIMEOUT_S, 15, seconds allowed per prompt; range 1..63

Ports:
clk  in  1  system clock (CLOCK_50 at top)
reset_n  in  1  synchronous reset, active low
prompt_valid  in  1  prompt offered
prompt_ready  out  1  block can accept a prompt
prompt_mask  in  10  switches the player must flip (expected one-hot)
sw  in  10  raw board switches (asynchronous)
result_valid  out  1  verdict available
result_ready  in  1  verdict consumed
result_code  out  2  00 BAD_PROMPT, 01 CORRECT, 10 WRONG, 11 TIMEOUT
secs_left  out  6  remaining seconds of current prompt
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset_n low at posedge clk, any state, including mid-debounce or mid-report): state IDLE; prompt_ready=1, result_valid=0, result_code=00, secs_left=0, busy=0; sync flops, counters and latches cleared. Takes effect on the next edge.
- sw passes through a 2-flop synchronizer; sw_s is the synchronized vector used everywhere.
- FSM states: IDLE, WAIT, SETTLE, JUDGE, REPORT.
- IDLE: prompt_ready=1. On prompt_valid&&prompt_ready:
  - baseline<=sw_s; expected<=sw_s^prompt_mask; secs_left<=TIMEOUT_S; tick_cnt<=0.
  - If prompt_mask==0: code<=BAD_PROMPT, go to REPORT.
  - Otherwise go to WAIT.
  - prompt_mask with multiple bits set is legal: every masked bit must flip.
- WAIT: if sw_s!=baseline: cand<=sw_s, deb_cnt<=0, go to SETTLE.
- SETTLE:
  - If sw_s==baseline: return to WAIT (bounce back).
  - Else if sw_s!=cand: cand<=sw_s, deb_cnt<=0.
  - Else if deb_cnt==DEBOUNCE_CYCLES-1: go to JUDGE.
  - Else deb_cnt++.
  - Dwell for a stable change is exactly DEBOUNCE_CYCLES cycles.
- JUDGE (one cycle): code<=CORRECT if cand==expected, else WRONG. Full 10-bit compare, so any extra or missing flip is WRONG. Go to REPORT.
- REPORT:
  - result_valid=1; result_code held stable until result_ready sampled high.
  - On result_valid&&result_ready: go to IDLE. result_valid drops and prompt_ready rises on the same edge.
  - Switch activity in REPORT is ignored.
- Countdown (WAIT and SETTLE only):
  - tick_cnt counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps and secs_left decrements.
  - When the decrement takes secs_left from 1 to 0: code<=TIMEOUT, go to REPORT on that same edge.
  - Timeout has priority over a debounce completion or a WAIT->SETTLE move on the same edge.
  - secs_left is frozen in JUDGE/REPORT and holds its value in IDLE until the next prompt is accepted.
- Latency: clean sw change at pins -> result_valid high after DEBOUNCE_CYCLES+4 clk edges (2 sync, 1 WAIT detect, DEBOUNCE_CYCLES settle, 1 judge).
- Exactly one verdict per accepted prompt; a prompt offered while busy is not accepted (prompt_ready=0).

Optional Feature:
STREAK_COUNT_EN:
- Defined: adds output port streak [7:0], reset 0. Increments (saturating at 255) on each CORRECT handshake. Cleared on WRONG, TIMEOUT or BAD_PROMPT handshake. Updates on the result_valid&&result_ready edge.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
(Params DEBOUNCE_CYCLES=4, TICK_DIV=10, TIMEOUT_S=3; result_ready tied 1 unless stated.)
- Reset mid-SETTLE: sw=0, prompt_mask=10'h004 accepted, flip sw[2], pull reset_n low 2 cycles into SETTLE -> next edge state IDLE, prompt_ready=1, result_valid=0, secs_left=0, no verdict issued.
- Correct response: sw=0, prompt_mask=10'h004 accepted, sw->10'h004 clean -> result_valid rises exactly 8 edges later with result_code=01, secs_left=3.
- Wrong and bounce: prompt_mask=10'h001; sw toggles 10'h001/10'h000 every 2 cycles for 10 cycles, then settles at 10'h003 -> result_code=10 only after 4 stable cycles; no verdict during the bouncing.
- Timeout: prompt_mask=10'h200 accepted, sw untouched -> secs_left steps 3,2,1 every 10 cycles; result_code=11 on the 30th cycle after accept; a debounce completing on that same edge still yields 11.
- Bad prompt and backpressure: prompt_mask=0 with result_ready=0 -> result_valid=1, code=00 held for 5 cycles, prompt_ready=0; raise result_ready -> IDLE next edge, a new prompt is accepted.
- STREAK_COUNT_EN: three CORRECT verdicts then one TIMEOUT -> streak 1,2,3,0.

Source files
------------

// File: rtl/prompt_response_judge.sv
// prompt_response_judge
//   Player-side end of the LED prompt protocol. Accepts a switch prompt,
//   synchronizes and debounces the board switches, then judges the settled
//   response against the prompt. Each accepted prompt gets exactly one verdict
//   over a valid/ready handshake. The per-round countdown drives secs_left.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   prompt_valid/ready        prompt handshake (ready only in IDLE)
//   prompt_mask[9:0]          switches the player must flip
//   sw[9:0]                   raw asynchronous board switches
//   result_valid/ready        verdict handshake
//   result_code[1:0]          00 BAD_PROMPT, 01 CORRECT, 10 WRONG, 11 TIMEOUT
//   secs_left[5:0]            remaining seconds of the current prompt
//   busy                      high in every state except IDLE
//   streak[7:0]               consecutive CORRECT count (STREAK_COUNT_EN only)
//
// Optional feature macro: STREAK_COUNT_EN
module prompt_response_judge #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_DIV        = 50000000,
    parameter int unsigned TIMEOUT_S       = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       prompt_valid,
    output logic       prompt_ready,
    input  logic [9:0] prompt_mask,
    input  logic [9:0] sw,
    output logic       result_valid,
    input  logic       result_ready,
    output logic [1:0] result_code,
    output logic [5:0] secs_left,
    output logic       busy
`ifdef STREAK_COUNT_EN
    ,
    output logic [7:0] streak
`endif
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [5:0]    SECS_INIT = 6'(TIMEOUT_S);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETTLE,
        ST_JUDGE,
        ST_REPORT
    } state_t;

    typedef enum logic [1:0] {
        CODE_BAD     = 2'b00,
        CODE_CORRECT = 2'b01,
        CODE_WRONG   = 2'b10,
        CODE_TIMEOUT = 2'b11
    } code_t;

    state_t        state_q, state_d;
    code_t         code_q, code_d;
    logic [9:0]    sw_meta_q, sw_s_q;
    logic [9:0]    baseline_q, baseline_d;
    logic [9:0]    expected_q, expected_d;
    logic [9:0]    cand_q, cand_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [5:0]    secs_q, secs_d;
    logic          timeout_hit;
`ifdef STREAK_COUNT_EN
    logic [7:0]    streak_q, streak_d;
`endif

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        baseline_d  = baseline_q;
        expected_d  = expected_q;
        cand_d      = cand_q;
        deb_cnt_d   = deb_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        secs_d      = secs_q;
        timeout_hit = 1'b0;

        // Countdown runs only while waiting for the player's response.
        if (state_q == ST_WAIT || state_q == ST_SETTLE) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d  = '0;
                secs_d      = secs_q - 6'd1;
                timeout_hit = (secs_q == 6'd1);
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (prompt_valid) begin
                    baseline_d = sw_s_q;
                    expected_d = sw_s_q ^ prompt_mask;
                    secs_d     = SECS_INIT;
                    tick_cnt_d = '0;
                    if (prompt_mask == '0) begin
                        code_d  = CODE_BAD;
                        state_d = ST_REPORT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Timeout outranks a switch change seen on the same edge.
                if (timeout_hit) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = ST_REPORT;
                end else if (sw_s_q != baseline_q) begin
                    cand_d    = sw_s_q;
                    deb_cnt_d = '0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Timeout outranks a debounce completing on the same edge.
                if (timeout_hit) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = ST_REPORT;
                end else if (sw_s_q == baseline_q) begin
                    state_d = ST_WAIT;
                end else if (sw_s_q != cand_q) begin
                    cand_d    = sw_s_q;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = ST_JUDGE;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            ST_JUDGE: begin
                code_d  = (cand_q == expected_q) ? CODE_CORRECT : CODE_WRONG;
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef STREAK_COUNT_EN
    always_comb begin
        streak_d = streak_q;
        if (state_q == ST_REPORT && result_ready) begin
            if (code_q == CODE_CORRECT) begin
                streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
            end else begin
                streak_d = '0;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            code_q     <= CODE_BAD;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            baseline_q <= '0;
            expected_q <= '0;
            cand_q     <= '0;
            deb_cnt_q  <= '0;
            tick_cnt_q <= '0;
            secs_q     <= '0;
`ifdef STREAK_COUNT_EN
            streak_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
            baseline_q <= baseline_d;
            expected_q <= expected_d;
            cand_q     <= cand_d;
            deb_cnt_q  <= deb_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            secs_q     <= secs_d;
`ifdef STREAK_COUNT_EN
            streak_q   <= streak_d;
`endif
        end
    end

    assign prompt_ready = (state_q == ST_IDLE);
    assign result_valid = (state_q == ST_REPORT);
    assign busy         = (state_q != ST_IDLE);
    assign result_code  = code_q;
    assign secs_left    = secs_q;
`ifdef STREAK_COUNT_EN
    assign streak       = streak_q;
`endif

endmodule

// File: tb/tb_prompt_response_judge.sv
// Testbench for prompt_response_judge: directed scenarios followed by
// randomized prompts. Each prompt's switch trace is planned up front and the
// verdict, its timing and secs_left are derived from the trace directly.
module tb_prompt_response_judge;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TDIV = 10;
    localparam int unsigned TOS  = 3;
    localparam int unsigned TLIM = TOS * TDIV;
    localparam int unsigned NPIN = 48;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       prompt_valid;
    logic       prompt_ready;
    logic [9:0] prompt_mask;
    logic [9:0] sw;
    logic       result_valid;
    logic       result_ready;
    logic [1:0] result_code;
    logic [5:0] secs_left;
    logic       busy;
`ifdef STREAK_COUNT_EN
    logic [7:0] streak;
`endif

    always #5 clk = ~clk;

    prompt_response_judge #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV(TDIV),
        .TIMEOUT_S(TOS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .prompt_valid(prompt_valid),
        .prompt_ready(prompt_ready),
        .prompt_mask(prompt_mask),
        .sw(sw),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_code(result_code),
        .secs_left(secs_left),
        .busy(busy)
`ifdef STREAK_COUNT_EN
        ,
        .streak(streak)
`endif
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [9:0]  pin [NPIN];   // pin[k]: switch value driven during cycle k after accept
    logic [7:0]  streak_m = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Verdict from the switch trace: the synchronized value seen in cycle k is
    // the pin value from cycle k-2. A verdict forms once DEB+1 consecutive
    // synchronized samples agree on a non-baseline value, provided that happens
    // before the time limit expires.
    task automatic model(input logic [9:0] base, input logic [9:0] mask,
                         output int unsigned r, output logic [1:0] code,
                         output logic [5:0] secs);
        logic [9:0]  prev;
        logic [9:0]  s;
        int unsigned run;
        bit          found;
        r = TLIM; code = 2'b11; secs = 6'd0;
        if (mask == 10'd0) begin
            r = 0; code = 2'b00; secs = 6'(TOS);
        end else begin
            prev = base; run = 0; found = 1'b0;
            for (int unsigned k = 1; k < TLIM && !found; k++) begin
                s    = (k <= 2) ? base : pin[k-2];
                run  = (s == prev) ? run + 1 : 1;
                prev = s;
                if (s != base && run >= DEB + 1) begin
                    found = 1'b1;
                    r     = k + 1;
                    code  = (s == (base ^ mask)) ? 2'b01 : 2'b10;
                    secs  = 6'(TOS - k / TDIV);
                end
            end
        end
    endtask

    task automatic gen_step(input logic [9:0] base, input logic [9:0] val, input int unsigned at);
        for (int unsigned k = 1; k < NPIN; k++) pin[k] = (k < at) ? base : val;
    endtask

    task automatic gen_random(input logic [9:0] base, input logic [9:0] mask);
        int unsigned k;
        int unsigned len;
        logic [9:0]  v;
        k = 1;
        while (k < NPIN) begin
            case ($urandom_range(3, 0))
                0:       v = base;
                1, 2:    v = base ^ mask;
                default: v = base ^ mask ^ (10'd1 << $urandom_range(9, 0));
            endcase
            len = $urandom_range(7, 1);
            for (int unsigned j = 0; j < len && k < NPIN; j++) begin
                pin[k] = v;
                k++;
            end
        end
    endtask

    task automatic run_prompt(input string name, input logic [9:0] base, input logic [9:0] mask,
                              input int unsigned rdly, input bit noise);
        int unsigned r;
        logic [1:0]  ecode;
        logic [5:0]  esecs;
        pin[0] = base;
        model(base, mask, r, ecode, esecs);
        result_ready = (rdly == 0);
        prompt_valid = 1'b0;
        sw = base;
        repeat (3) @(posedge clk);
        #1;
        chk({name, ":idle_ready"}, 32'(prompt_ready), 32'd1);
        for (int unsigned k = 0; k <= r; k++) begin
            sw           = pin[k];
            prompt_valid = (k == 0) ? 1'b1 : noise;
            prompt_mask  = (k == 0) ? mask : 10'($urandom);
            @(posedge clk);
            #1;
            if (k < r) begin
                chk({name, ":early_valid"}, 32'(result_valid), 32'd0);
                chk({name, ":secs_run"}, 32'(secs_left), 32'(TOS - k / TDIV));
                chk({name, ":busy"}, 32'(busy), 32'd1);
            end
        end
        chk({name, ":valid"}, 32'(result_valid), 32'd1);
        chk({name, ":code"}, 32'(result_code), 32'(ecode));
        chk({name, ":secs_final"}, 32'(secs_left), 32'(esecs));
        chk({name, ":ready_busy"}, 32'(prompt_ready), 32'd0);
        for (int unsigned i = 0; i < rdly; i++) begin
            sw = 10'($urandom);
            @(posedge clk);
            #1;
            chk({name, ":hold_valid"}, 32'(result_valid), 32'd1);
            chk({name, ":hold_code"}, 32'(result_code), 32'(ecode));
            chk({name, ":hold_ready"}, 32'(prompt_ready), 32'd0);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        prompt_valid = 1'b0;
        chk({name, ":done_valid"}, 32'(result_valid), 32'd0);
        chk({name, ":done_ready"}, 32'(prompt_ready), 32'd1);
        chk({name, ":done_busy"}, 32'(busy), 32'd0);
        chk({name, ":secs_hold"}, 32'(secs_left), 32'(esecs));
`ifdef STREAK_COUNT_EN
        streak_m = (ecode == 2'b01) ? ((streak_m == 8'hFF) ? streak_m : streak_m + 8'd1) : 8'd0;
        chk({name, ":streak"}, 32'(streak), 32'(streak_m));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  base;
        logic [9:0]  mask;
        int unsigned sel;
        bit          seen;

        reset_n = 1'b0; prompt_valid = 1'b0; prompt_mask = '0; sw = '0; result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(prompt_ready), 32'd1);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_code", 32'(result_code), 32'd0);
        chk("rst_secs", 32'(secs_left), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        // Reset while the response is settling.
        repeat (3) @(posedge clk);
        #1;
        prompt_mask = 10'h004; prompt_valid = 1'b1;
        @(posedge clk);
        #1;
        prompt_valid = 1'b0; sw = 10'h004;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 32'(prompt_ready), 32'd1);
        chk("mid_rst_valid", 32'(result_valid), 32'd0);
        chk("mid_rst_secs", 32'(secs_left), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (result_valid) seen = 1'b1;
        end
        chk("mid_no_verdict", 32'(seen), 32'd0);
`ifdef STREAK_COUNT_EN
        chk("mid_streak", 32'(streak), 32'd0);
`endif

        gen_step(10'h000, 10'h004, 1);
        run_prompt("correct1", 10'h000, 10'h004, 0, 1'b0);
        gen_step(10'h010, 10'h090, 3);
        run_prompt("correct2", 10'h010, 10'h080, 0, 1'b1);
        gen_step(10'h3FF, 10'h3FD, 5);
        run_prompt("correct3", 10'h3FF, 10'h002, 0, 1'b0);
        gen_step(10'h000, 10'h200, 24);
        run_prompt("tmo_edge", 10'h000, 10'h200, 0, 1'b0);
        gen_step(10'h000, 10'h000, 1);
        run_prompt("tmo_idle", 10'h000, 10'h200, 0, 1'b1);

        for (int unsigned k = 1; k < NPIN; k++)
            pin[k] = (k > 10) ? 10'h003 : ((((k - 1) / 2) % 2 == 0) ? 10'h001 : 10'h000);
        run_prompt("bounce", 10'h000, 10'h001, 0, 1'b0);

        gen_step(10'h000, 10'h000, 1);
        run_prompt("bad", 10'h000, 10'h000, 5, 1'b1);

        for (int t = 0; t < 40; t++) begin
            base = 10'($urandom);
            sel  = $urandom_range(9, 0);
            if (sel == 0)      mask = 10'd0;
            else if (sel < 3)  mask = 10'($urandom_range(1023, 1));
            else               mask = 10'd1 << $urandom_range(9, 0);
            gen_random(base, mask);
            run_prompt("rnd", base, mask, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
